// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block.
//   state_e   : per-channel press/repeat FSM state encoding
//   cnt_width : width of a counter that must reach the largest of three cycle limits
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    // Wide enough to hold max(a, b, c) without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, counter debouncer and
// press / hold-to-repeat pulse FSM.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_raw    asynchronous raw button level, 1 = pressed
//   btn_level  debounced level, 1 = pressed
//   btn_pulse  one-cycle pulse per press and per repeat tick
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q,   sync1_d;
    logic             sync2_q,   sync2_d;
    logic [CNT_W-1:0] db_cnt_q,  db_cnt_d;
    logic             level_q,   level_d;
    logic             pulse_q,   pulse_d;
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rise;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;

        // Debounce: count consecutive cycles the synchronized input disagrees
        // with the current level; any agreement restarts the count.
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // The FSM reacts to the level being registered this edge, so the press
        // pulse lands in exactly the same cycle the debounced level rises.
        rise = level_d & ~level_q;

        // Repeat timers count from the pulse cycle; the !pulse_q guard keeps
        // a limit of 1 from producing back-to-back pulses.
        case (state_q)
            IDLE: begin
                if (rise) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = (REPEAT_EN != 0) ? HOLD : WAIT_REL;
                end
            end
            HOLD: begin
                if (!level_d) begin
                    state_d = IDLE;
                end else if (rpt_cnt_q >= DELAY_LAST && !pulse_q) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = REPEAT;
                end else if (rpt_cnt_q < DELAY_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!level_d) begin
                    state_d = IDLE;
                end else if (rpt_cnt_q >= PERIOD_LAST && !pulse_q) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q < PERIOD_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!level_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// N_BTN independent push-button channels producing debounced levels and
// clean one-cycle event pulses (press and optional hold-to-repeat).
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_raw    [N_BTN] asynchronous raw button levels, 1 = pressed
//   btn_level  [N_BTN] debounced button levels
//   btn_pulse  [N_BTN] one-cycle pulse per press event / repeat tick
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .btn_pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: two instances share the raw inputs, one with
// auto-repeat off (d0) and one with it on (d1). Expected pulse cycles are
// queued per instance/channel when stimulus is driven and compared every cycle.
module tb_btn_debounce_pulse;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] lvl0, pls0, lvl1, pls1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    int         exp_q[2][4][$];
    logic [3:0] prev_pls[2];

    btn_debounce_pulse #(
        .N_BTN(4), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) u_dut0 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl0), .btn_pulse(pls0)
    );

    btn_debounce_pulse #(
        .N_BTN(4), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) u_dut1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl1), .btn_pulse(pls1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected pulses for a press debounced from cycle t and released at t_rel:
    // both instances pulse at t+6; the repeating one then pulses after DLY and
    // every PER cycles while the level is still high (it falls at t_rel+6).
    task automatic push_hold(input int ch, input int t, input int t_rel);
        int c;
        exp_q[0][ch].push_back(t + 2 + DEB);
        exp_q[1][ch].push_back(t + 2 + DEB);
        c = t + 2 + DEB + DLY;
        while (c < t_rel + 2 + DEB) begin
            exp_q[1][ch].push_back(c);
            c += PER;
        end
    endtask

    task automatic chk_lvl(input string tag, input int ch, input logic v);
        check({tag, "_d0"}, 32'(lvl0[ch]), 32'(v));
        check({tag, "_d1"}, 32'(lvl1[ch]), 32'(v));
    endtask

    // Pulse monitor: a pulse is required exactly at each queued cycle and
    // forbidden at every other cycle; back-to-back pulses are always an error.
    initial begin
        prev_pls[0] = '0;
        prev_pls[1] = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [3:0] p;
                p = (d == 0) ? pls0 : pls1;
                if (|(p & prev_pls[d]))
                    check($sformatf("pulse_back_to_back_d%0d", d), 32'(p & prev_pls[d]), 32'd0);
                for (int ch = 0; ch < 4; ch++) begin
                    if (exp_q[d][ch].size() > 0 && exp_q[d][ch][0] == cyc) begin
                        void'(exp_q[d][ch].pop_front());
                        check($sformatf("pulse_d%0d_ch%0d", d, ch), 32'(p[ch]), 32'd1);
                    end else if (p[ch] !== 1'b0) begin
                        check($sformatf("unexpected_pulse_d%0d_ch%0d", d, ch), 32'(p[ch]), 32'd0);
                    end
                end
                prev_pls[d] = p;
            end
        end
    end

    initial begin
        int t, t_rel, t0, r;

        // 1: reset with all buttons pressed
        rst     = 1'b1;
        btn_raw = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_level_d0", 32'(lvl0), 32'd0);
            check("rst_pulse_d0", 32'(pls0), 32'd0);
            check("rst_level_d1", 32'(lvl1), 32'd0);
            check("rst_pulse_d1", 32'(pls1), 32'd0);
        end
        rst     = 1'b0;
        btn_raw = 4'b0000;
        wait_neg(10);

        // 2: clean press and hold on ch0
        btn_raw[0] = 1'b1;
        t = cyc;
        push_hold(0, t, t + 40);
        wait_neg(5);  chk_lvl("t2_level_before", 0, 1'b0);
        wait_neg(1);  chk_lvl("t2_level_rise", 0, 1'b1);
        wait_neg(34); btn_raw[0] = 1'b0;
        wait_neg(5);  chk_lvl("t2_level_before_fall", 0, 1'b1);
        wait_neg(1);  chk_lvl("t2_level_fall", 0, 1'b0);
        wait_neg(10);

        // 3: bouncing ch1, toggling every 2 cycles, then settling high
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            btn_raw[1] = ~btn_raw[1];
            wait_neg(2);
        end
        chk_lvl("t3_level_during_bounce", 1, 1'b0);
        check("t3_bounce_span", 32'(cyc - t0), 32'd12);
        btn_raw[1] = 1'b1;
        t = cyc;
        push_hold(1, t, t + 20);
        wait_neg(5);  chk_lvl("t3_level_before", 1, 1'b0);
        wait_neg(1);  chk_lvl("t3_level_rise", 1, 1'b1);
        wait_neg(14); btn_raw[1] = 1'b0;
        wait_neg(6);  chk_lvl("t3_level_fall", 1, 1'b0);
        wait_neg(10);

        // 4: hold-to-repeat on ch2
        btn_raw[2] = 1'b1;
        t = cyc;
        push_hold(2, t, t + 40);
        wait_neg(6);  chk_lvl("t4_level_rise", 2, 1'b1);
        wait_neg(34); btn_raw[2] = 1'b0;
        t_rel = cyc;
        wait_neg(6);  chk_lvl("t4_level_fall", 2, 1'b0);
        check("t4_release_latency", 32'(cyc - t_rel), 32'd6);
        wait_neg(10);

        // 5: simultaneous presses on ch0 and ch3
        btn_raw = 4'b1001;
        t = cyc;
        push_hold(0, t, t + 20);
        push_hold(3, t, t + 20);
        wait_neg(6);
        check("t5_levels_d0", 32'(lvl0), 32'h9);
        check("t5_levels_d1", 32'(lvl1), 32'h9);
        wait_neg(14); btn_raw = 4'b0000;
        wait_neg(16);

        // 6: reset while ch2 is repeating, button kept held
        btn_raw[2] = 1'b1;
        t = cyc;
        push_hold(2, t, t + 14);
        wait_neg(20);
        rst = 1'b1;
        wait_neg(1);
        rst = 1'b0;
        check("t6_rst_level_d0", 32'(lvl0), 32'd0);
        check("t6_rst_pulse_d0", 32'(pls0), 32'd0);
        check("t6_rst_level_d1", 32'(lvl1), 32'd0);
        check("t6_rst_pulse_d1", 32'(pls1), 32'd0);
        r = cyc;
        push_hold(2, r, r + 30);
        wait_neg(5);  chk_lvl("t6_level_before", 2, 1'b0);
        wait_neg(1);  chk_lvl("t6_level_rise", 2, 1'b1);
        wait_neg(24); btn_raw[2] = 1'b0;
        wait_neg(16);

        // every queued pulse must have been consumed
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 4; ch++)
                check($sformatf("pending_pulses_d%0d_ch%0d", d, ch),
                      32'(exp_q[d][ch].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
